// File: rtl/chunked_adder_pkg.sv
// chunked_adder_pkg: shared state type and slice width for chunked_adder_ctrl
package chunked_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_W = 4;
endpackage

// File: rtl/parallel_adder.sv
// parallel_adder: 4-bit adder slice with carry in and carry out
module parallel_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum_out,
  output logic       carry_out
);
  assign {carry_out, sum_out} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/chunked_adder_ctrl.sv
// chunked_adder_ctrl: WIDTH-bit add streamed 4 bits/cycle through one slice; SUB_EN adds op (invert b)
module chunked_adder_ctrl
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SUB_EN
  input  logic             op,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             busy
);
  localparam int N = WIDTH / SLICE_W;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  state_t state;
  logic [N-1:0][SLICE_W-1:0] a_reg, b_reg, work_sum, next_sum;
  logic carry_reg;
  logic [IW-1:0] idx;
  logic [SLICE_W-1:0] s_sum;
  logic s_cout;
  logic [WIDTH-1:0] b_in;
`ifdef SUB_EN
  assign b_in = op ? ~b : b;
`else
  assign b_in = b;
`endif
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  parallel_adder u_slice (
    .a(a_reg[idx]),
    .b(b_reg[idx]),
    .cin(carry_reg),
    .sum_out(s_sum),
    .carry_out(s_cout)
  );
  // working sum with the current slice merged in, so the final result includes it
  always_comb begin
    next_sum = work_sum;
    next_sum[idx] = s_sum;
  end
  // sequencing FSM: capture, one slice per RUN cycle, hold result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      work_sum <= '0;
      carry_reg <= 1'b0;
      idx <= '0;
      sum_out <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg <= a;
          b_reg <= b_in;
          carry_reg <= cin;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          work_sum <= next_sum;
          carry_reg <= s_cout;
          idx <= idx + 1'b1;
          if (idx == IW'(N - 1)) begin
            sum_out <= next_sum;
            carry_out <= s_cout;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/chunked_adder_ctrl.md
# chunked_adder_ctrl

Sequencing controller that performs a WIDTH-bit addition by streaming operands 4 bits per cycle through a single 4-bit parallel adder slice, carrying between slices in a register. It sits between a valid/ready operand source and a valid/ready result sink. Wide operands therefore cost one small adder instead of a WIDTH-bit ripple chain.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set offered
- in_ready  out  1  controller can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry into slice 0
- op  in  1  0 = add, 1 = subtract-style (b inverted); present only with SUB_EN
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- sum_out  out  WIDTH  result
- carry_out  out  1  carry out of top slice
- busy  out  1  high in RUN or DONE

## Operation
- N = WIDTH/4 slices; slice i = bits [4i+3:4i]; slice counter `idx` is max(1, clog2(N)) bits.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture a, b (b inverted when op=1 under SUB_EN) into working registers, carry_reg <= cin, idx <= 0, go to RUN. Inputs are ignored at all other times.
  - RUN: the slice adds a_reg[idx] + b_reg[idx] + carry_reg. The slice sum is written to work_sum[idx], carry_reg <= slice cout, idx <= idx+1. When idx == N-1, load sum_out <= the final work_sum (including the current slice) and carry_out <= slice cout, then go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- sum_out and carry_out are written only on the RUN->DONE transition. They hold that value until the next completion or reset, and they never show partial results.
- Arithmetic is modulo 2^WIDTH. carry_out is bit WIDTH of a + b' + cin, where b' is b or ~b.
- The controller never drops operands and never produces a result without an acceptance.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum_out=0, carry_out=0, state=IDLE, carry_reg=0, idx=0.
- Acceptance at edge E0 puts the block in RUN, and out_valid rises after edge E0+N. Latency is N cycles; for WIDTH=16 that is 4.
- Minimum issue interval is N+2 cycles. DONE->IDLE costs one edge, and in_ready is low in RUN and DONE.
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- out_ready low in DONE: the block stalls indefinitely with outputs stable.
- N=1 (WIDTH=4): RUN lasts one cycle and goes straight to DONE.
- rst asserted in any state returns all reset values at the next edge. An in-flight operation is discarded and no out_valid is produced for it.
- in_valid asserted during RUN/DONE has no effect. The source must hold its data until in_ready.

## Configuration
- SUB_EN defined: the op port exists. With op=1, b is stored as ~b, so op=1 with cin=1 yields a-b, and carry_out=1 means no borrow.
- SUB_EN undefined: the op port is absent and b is always stored unmodified (add only).

## Structure
- Package chunked_adder_pkg holds:
  - typedef of the state enum (IDLE, RUN, DONE)
  - localparam SLICE_W = 4
- One sub-module: the existing 4-bit parallel_adder slice (a, b, cin, sum_out, carry_out), instantiated once and driven by the indexed slice muxes.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum_out=0x5555, carry_out=0; out_valid rises exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0000, cin=1 -> sum_out=0x0000, carry_out=1. Checks that the carry ripples through all 4 slices via carry_reg.
- Hold out_ready=0 for 3 cycles in DONE while toggling a/b/in_valid -> sum_out, carry_out and out_valid are stable and in_ready=0; on out_ready=1, state returns to IDLE and the next in_valid is accepted.
- Assert rst for one cycle after 2 RUN slices of a=0xFFFF, b=0x0001 -> out_valid never rises, sum_out=0, carry_out=0, in_ready=1 on the next cycle.
- SUB_EN: a=0x0005, b=0x0007, op=1, cin=1 -> sum_out=0xFFFE, carry_out=0; a=0x0007, b=0x0005 -> 0x0002, carry_out=1.
- Back-to-back: in_valid held high with 3 random operand sets and out_ready=1 -> each result matches a+b+cin mod 2^16, with acceptances spaced exactly N+2=6 cycles apart.
